// File: rtl/alu_pkg.sv
// Shared definitions for the SIFO ALU: datapath width, opcode type and opcode map.
package alu_pkg;

  localparam int DATA_W = 10;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD = 5'b00101;
  localparam opcode_t OP_SUB = 5'b00111;
  localparam opcode_t OP_MUL = 5'b01001;
  localparam opcode_t OP_DIV = 5'b01011;
  localparam opcode_t OP_AND = 5'b01101;
  localparam opcode_t OP_OR  = 5'b01111;
  localparam opcode_t OP_XOR = 5'b10001;
  localparam opcode_t OP_CMP = 5'b10010;
  localparam opcode_t OP_SHL = 5'b10011;
  localparam opcode_t OP_SHR = 5'b10101;

  // True for every opcode that produces a result; anything else decodes as NOP.
  function automatic logic is_defined_op(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
      OP_OR, OP_XOR, OP_CMP, OP_SHL, OP_SHR: is_defined_op = 1'b1;
      default:                               is_defined_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Combinational unsigned restoring divider; a zero divisor yields an all-ones quotient.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient
);

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;

  // NOTE: blocking assignments here are intentional; each loop iteration
  // must see the partial remainder produced by the previous one.
  always_comb begin
    rem = '0;
    q   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem  = rem - {1'b0, divisor};
        q[i] = 1'b1;
      end
    end
  end

  // Restoring division already saturates for a zero divisor, but the rule is
  // made explicit so it cannot silently depend on the algorithm.
  assign quotient = (divisor == '0) ? '1 : q;

endmodule

// File: rtl/alu_core.sv
// Registered single-cycle ALU: opcode decode, s/g flag generation and output registers.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] res,
  output logic             s,
  output logic             g
);

  logic [WIDTH-1:0] quo;
  logic [3:0]       shamt;
  logic             shift_oob;
  logic [WIDTH-1:0] nxt_res;
  logic             nxt_s;
  logic             nxt_g;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .dividend (op1),
    .divisor  (op2),
    .quotient (quo)
  );

  assign shamt     = op2[3:0];
  assign shift_oob = (int'(shamt) >= WIDTH);

  // NOTE: every output of this block gets a default first so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    nxt_res = '0;
    case (opcode)
      OP_ADD:  nxt_res = op1 + op2;
      OP_SUB:  nxt_res = op1 - op2;
      OP_MUL:  nxt_res = op1 * op2;
      OP_DIV:  nxt_res = quo;
      OP_AND:  nxt_res = op1 & op2;
      OP_OR:   nxt_res = op1 | op2;
      OP_XOR:  nxt_res = op1 ^ op2;
      OP_SHL:  nxt_res = shift_oob ? '0 : (op1 << shamt);
      OP_SHR:  nxt_res = shift_oob ? '0 : (op1 >> shamt);
      default: nxt_res = '0;
    endcase
  end

  // CMP flags come from a true signed compare so overflow cannot corrupt them;
  // all other ops (NOP included) derive the flags from the result word.
  always_comb begin
    nxt_s = 1'b0;
    nxt_g = 1'b0;
    if (opcode == OP_CMP) begin
      nxt_s = $signed(op1) < $signed(op2);
      nxt_g = $signed(op1) > $signed(op2);
    end else if (is_defined_op(opcode)) begin
      nxt_s = nxt_res[WIDTH-1];
      nxt_g = (nxt_res != '0) && !nxt_res[WIDTH-1];
    end
  end

  // NOTE: registered state uses non-blocking assignments so all three outputs
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res <= '0;
      s   <= 1'b0;
      g   <= 1'b0;
    end else begin
      res <= nxt_res;
      s   <= nxt_s;
      g   <= nxt_g;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W    = 10;
  localparam int MODV = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    opcode;
  logic [W-1:0]  op1, op2;
  logic [W-1:0]  res;
  logic          s, g;

  int n_checks = 0;
  int n_fail   = 0;

  alu_core #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .op1    (op1),
    .op2    (op2),
    .res    (res),
    .s      (s),
    .g      (g)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model on plain integers: returns {res, s, g}.
  function automatic logic [W+1:0] model(input logic [4:0] opc, input int a, input int b);
    int r, amt, sa, sb;
    logic fs, fg;
    r = 0; fs = 0; fg = 0;
    amt = b % 16;
    case (opc)
      5'b00101: r = (a + b) % MODV;
      5'b00111: r = (a - b + MODV) % MODV;
      5'b01001: r = (a * b) % MODV;
      5'b01011: r = (b == 0) ? MODV - 1 : a / b;
      5'b01101: r = a & b;
      5'b01111: r = a | b;
      5'b10001: r = a ^ b;
      5'b10011: r = (amt >= W) ? 0 : (a * (1 << amt)) % MODV;
      5'b10101: r = (amt >= W) ? 0 : a / (1 << amt);
      default:  r = 0;
    endcase
    if (opc == 5'b10010) begin
      sa = (a >= MODV / 2) ? a - MODV : a;
      sb = (b >= MODV / 2) ? b - MODV : b;
      fs = sa < sb;
      fg = sa > sb;
    end else begin
      fs = r >= MODV / 2;
      fg = (r != 0) && (r < MODV / 2);
    end
    model = {r[W-1:0], fs, fg};
  endfunction

  // Compare process: expectation captured at each edge, checked on the falling edge.
  logic [W+1:0] exp_v;
  logic         started = 1'b0;

  always @(posedge clk) begin
    exp_v   <= rst_n ? model(opcode, int'(op1), int'(op2)) : '0;
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_res", int'(res), int'(exp_v[W+1:2]));
      check("cyc_s",   int'(s),   int'(exp_v[1]));
      check("cyc_g",   int'(g),   int'(exp_v[0]));
    end
  end

  // Drive one op, wait for the capturing edge, then check against literals.
  task automatic do_op(input string name, input logic [4:0] opc, input int a, input int b,
                       input int er, input int es, input int eg);
    opcode = opc;
    op1    = a[W-1:0];
    op2    = b[W-1:0];
    @(posedge clk); #1;
    check({name, "_res"}, int'(res), er);
    check({name, "_s"},   int'(s),   es);
    check({name, "_g"},   int'(g),   eg);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       pick_operand = 10'h000;
      1:       pick_operand = 10'h001;
      2:       pick_operand = 10'h1FF;
      3:       pick_operand = 10'h200;
      4:       pick_operand = 10'h3FF;
      default: pick_operand = W'($urandom_range(0, MODV - 1));
    endcase
  endfunction

  logic [4:0] valid_ops [10];
  logic [W+1:0] m;

  initial begin
    valid_ops = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_SHL, OP_SHR};

    // Pin the model against hand-computed values.
    m = model(OP_SUB, 2, 4);      check("model_sub", int'(m), (10'h3FE << 2) | 2);
    m = model(OP_MUL, 40, 40);    check("model_mul", int'(m), (576 << 2) | 2);
    m = model(OP_CMP, 10'h200, 1); check("model_cmp_neg", int'(m), 2);
    m = model(OP_CMP, 1, 10'h3FF); check("model_cmp_pos", int'(m), 1);
    m = model(OP_SHR, 10'h200, 12); check("model_shr_oob", int'(m), 0);
    m = model(OP_DIV, 7, 0);      check("model_div0", int'(m), (10'h3FF << 2) | 2);

    // Reset holds outputs at zero despite a live ADD.
    rst_n  = 1'b0;
    opcode = OP_ADD;
    op1    = 10'd2;
    op2    = 10'd4;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_res", int'(res), 0);
      check("rst_s",   int'(s),   0);
      check("rst_g",   int'(g),   0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_res", int'(res), 6);

    do_op("add",     OP_ADD, 2, 4, 6, 0, 1);
    do_op("sub",     OP_SUB, 2, 4, 10'h3FE, 1, 0);
    do_op("mul",     OP_MUL, 2, 4, 8, 0, 1);
    do_op("div",     OP_DIV, 2, 4, 0, 0, 0);
    do_op("cmp",     OP_CMP, 2, 4, 0, 1, 0);
    do_op("add_wrap", OP_ADD, 10'h3FF, 1, 0, 0, 0);
    do_op("mul_wrap", OP_MUL, 40, 40, 576, 1, 0);
    do_op("div0",    OP_DIV, 7, 0, 10'h3FF, 1, 0);
    do_op("cmp_neg", OP_CMP, 10'h200, 1, 0, 1, 0);
    do_op("cmp_eq",  OP_CMP, 5, 5, 0, 0, 0);
    do_op("cmp_pos", OP_CMP, 1, 10'h3FF, 0, 0, 1);
    do_op("and",     OP_AND, 10'h2AA, 10'h0F0, 10'h0A0, 0, 1);
    do_op("or",      OP_OR,  10'h2AA, 10'h0F0, 10'h2FA, 1, 0);
    do_op("xor",     OP_XOR, 10'h2AA, 10'h0F0, 10'h25A, 1, 0);
    do_op("shl",     OP_SHL, 1, 9, 10'h200, 1, 0);
    do_op("shr_oob", OP_SHR, 10'h200, 12, 0, 0, 0);
    do_op("shr",     OP_SHR, 10'h200, 9, 1, 0, 1);
    do_op("add_pre", OP_ADD, 3, 4, 7, 0, 1);
    do_op("nop",     5'b00000, 3, 4, 0, 0, 0);

    // Mid-stream reset discards the op sampled at that edge.
    opcode = OP_ADD; op1 = 10'd1; op2 = 10'd1; rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_res", int'(res), 0);
    rst_n = 1'b1;

    // Randomized back-to-back traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      opcode = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                           : valid_ops[$urandom_range(0, 9)];
      op1    = pick_operand();
      op2    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : pick_operand();
      rst_n  = ($urandom_range(0, 63) != 0);
      @(posedge clk); #1;
    end

    rst_n = 1'b1;
    opcode = 5'b00000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
